_demux_buf: RTL and testbench

- Variable-output, variable-width registered demultiplexer; the write-side counterpart of the `_mux` read-select block.
- Steers one valid/ready input stream to one of N_OUT output streams, chosen by `sel`.
- Each output has a one-entry holding register, so a stalled consumer blocks only its own lane.
- Used in the datapath wherever one result fans out to selectable destinations, such as writeback lanes or unit request ports.

---
 rtl/macros.sv | 14 +
 rtl/_demux_slot.sv | 30 +++
 rtl/_demux_buf.sv | 62 ++++++
 tb/tb__demux_buf.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/macros.sv
// Shared helper functions used by datapath blocks for parameter derivation.
package macros;

  // Ceiling log2, never below 1 so a 2-lane select still gets one bit.
  function automatic int log_2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/_demux_slot.sv
// One-entry holding register for a single demux output lane.
module _demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             ready
);

  assign ready = !valid | drain_ready;

  // A reload wins over a drain so a lane with an always-ready consumer streams at full rate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (valid && drain_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/_demux_buf.sv
// Registered valid/ready demultiplexer: steers one input stream to one of N_OUT held lanes.
module _demux_buf #(
  parameter int N_OUT = 2,
  parameter int WIDTH = 32,
  parameter int SEL_W = macros::log_2(N_OUT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEL_W-1:0]            sel,
  input  logic [WIDTH-1:0]            in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_OUT-1:0][WIDTH-1:0] out,
  output logic [N_OUT-1:0]            out_valid,
  input  logic [N_OUT-1:0]            out_ready,
  output logic                        err_sel,
  output logic [7:0]                  err_cnt
);

  logic [N_OUT-1:0] slot_ready;
  logic [N_OUT-1:0] load;
  logic             illegal;
  logic             lane_ready;

  // Illegal selects are always accepted and dropped so the producer never stalls on them.
  always_comb begin
    illegal    = (int'(sel) >= N_OUT);
    lane_ready = 1'b0;
    load       = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (sel == SEL_W'(i)) lane_ready = slot_ready[i];
    end
    in_ready = rst_n & (illegal | lane_ready);
    for (int i = 0; i < N_OUT; i++) begin
      load[i] = in_valid & in_ready & (sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    _demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load[g]),
      .data        (in),
      .drain_ready (out_ready[g]),
      .q           (out[g]),
      .valid       (out_valid[g]),
      .ready       (slot_ready[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err_sel <= in_valid & illegal;
      if (in_valid && illegal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb__demux_buf.sv
// Scoreboard bench for _demux_buf with N_OUT=5 so illegal selects (5..7) are reachable.
module tb__demux_buf;

  localparam int N_OUT = 5;
  localparam int WIDTH = 32;
  localparam int SEL_W = 3;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [SEL_W-1:0]            sel;
  logic [WIDTH-1:0]            din;
  logic                        in_valid;
  logic                        in_ready;
  logic [N_OUT-1:0][WIDTH-1:0] dout;
  logic [N_OUT-1:0]            out_valid;
  logic [N_OUT-1:0]            out_ready;
  logic                        err_sel;
  logic [7:0]                  err_cnt;

  int vectors  = 0;
  int failures = 0;

  // Reference model: each lane is a FIFO of accepted-but-unconsumed beats.
  logic [WIDTH-1:0] lane_q [N_OUT][$];
  logic [N_OUT-1:0] pushed;
  logic             exp_ready;
  logic             last_illegal;
  logic             err_due;
  int               exp_cnt;

  _demux_buf #(.N_OUT(N_OUT), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] s,
                               input logic [WIDTH-1:0] d, input logic [N_OUT-1:0] r);
    @(posedge clk);
    #1;
    if (last_illegal && exp_cnt < 255) exp_cnt++;
    err_due   = last_illegal;
    in_valid  = v;
    sel       = s;
    din       = d;
    out_ready = r;
    pushed    = '0;
    if (int'(s) >= N_OUT) begin
      exp_ready    = 1'b1;
      last_illegal = v;
    end else begin
      exp_ready    = (lane_q[s].size() == 0) || r[s];
      last_illegal = 1'b0;
      if (v && exp_ready) begin
        lane_q[s].push_back(d);
        pushed[s] = 1'b1;
      end
    end
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = '0;
    sel       = '0;
    for (int i = 0; i < N_OUT; i++) lane_q[i].delete();
    pushed       = '0;
    last_illegal = 1'b0;
    err_due      = 1'b0;
    exp_cnt      = 0;
    exp_ready    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_ready = 1'b1;
  endtask

  // Monitor: compares at the falling edge, consuming a beat wherever the lane hands one off.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    end else begin
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      checkOutput("err_sel", {31'd0, err_sel}, {31'd0, err_due});
      checkOutput("err_cnt", {24'd0, err_cnt}, 32'(exp_cnt));
      for (int i = 0; i < N_OUT; i++) begin
        int held;
        held = lane_q[i].size() - int'(pushed[i]);
        checkOutput($sformatf("out_valid[%0d]", i), {31'd0, out_valid[i]}, {31'd0, held > 0});
        if (held > 0) begin
          checkOutput($sformatf("out[%0d]", i), dout[i], lane_q[i][0]);
          if (out_ready[i]) void'(lane_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = '0; din = '0; out_ready = '0;
    pushed = '0; exp_ready = 1'b0; last_illegal = 1'b0; err_due = 1'b0; exp_cnt = 0;

    doReset(2);
    for (int s = 0; s < 8; s++) applyStimulus(1'b0, SEL_W'(s), '0, '0);

    // Single transfer into lane 2 held against a stalled consumer.
    applyStimulus(1'b1, 3'd2, 32'hDEADBEEF, '0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, (k % 2 == 0) ? 3'd2 : 3'd0, '0, '0);

    // Back-to-back streaming into lane 4 with an always-ready consumer.
    for (int k = 1; k <= 10; k++) applyStimulus(1'b1, 3'd4, 32'(k), 5'b10000);
    applyStimulus(1'b0, 3'd4, '0, 5'b10000);

    // Drain and reload of lane 1 in the same cycle.
    applyStimulus(1'b1, 3'd1, 32'h11, '0);
    applyStimulus(1'b1, 3'd1, 32'h22, 5'b00010);
    applyStimulus(1'b0, 3'd1, '0, '0);
    applyStimulus(1'b0, 3'd1, '0, 5'b00010);

    // Illegal select held long enough to saturate the error counter.
    for (int k = 0; k < 300; k++) applyStimulus(1'b1, 3'd6, $urandom, 5'b11111);
    applyStimulus(1'b0, 3'd0, '0, 5'b11111);
    applyStimulus(1'b0, 3'd0, '0, 5'b11111);

    // Reset while lanes 0 and 3 are holding stalled data.
    applyStimulus(1'b1, 3'd0, 32'hA0A0A0A0, '0);
    applyStimulus(1'b1, 3'd3, 32'h33333333, '0);
    doReset(1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, SEL_W'(k), '0, '0);

    // Randomised traffic across legal and illegal selects with random back-pressure.
    for (int k = 0; k < 1500; k++)
      applyStimulus(1'($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 7)),
                    $urandom, N_OUT'($urandom));

    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 3'd0, '0, '1);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
